// File: rtl/div_softmax_pkg.sv
// Shared constants and shift decode for the multi-lane pow2 softmax divider.
// calc_shift turns a signed exponent into a shift amount and direction:
//   e = -floor_shift when exp <= floor_exp, else exp + bias
//   e > max_rshift            -> right by max_rshift
//   0 < e <= max_rshift       -> right by e
//   -floor_shift <= e <= 0    -> left by -e (e == 0 is pass-through)
//   e < -floor_shift          -> left by floor_shift
package div_softmax_pkg;

    localparam int LANES_DEF       = 4;
    localparam int EXP_W_DEF       = 8;
    localparam int DIV_W_DEF       = 24;
    localparam int OUT_W_DEF       = 16;
    localparam int BIAS_DEF        = 4;
    localparam int EXP_FLOOR_DEF   = -20;
    localparam int FLOOR_SHIFT_DEF = 16;
    localparam int MAX_RSHIFT_DEF  = 12;
    localparam int ROUND_EN_DEF    = 1;

    localparam int SHAMT_W = 8;

    typedef struct packed {
        logic               right;
        logic [SHAMT_W-1:0] amt;
    } shift_t;

    // The exponent arrives sign-extended to 32 bits, so exp + bias cannot wrap.
    function automatic shift_t calc_shift(input logic signed [31:0] exp_v,
                                          input int bias,
                                          input int floor_exp,
                                          input int floor_shift,
                                          input int max_rshift);
        int     e;
        shift_t r;
        if (exp_v <= floor_exp) e = -floor_shift;
        else                    e = exp_v + bias;
        r.right = 1'b0;
        r.amt   = '0;
        if (e > max_rshift) begin
            r.right = 1'b1;
            r.amt   = SHAMT_W'(max_rshift);
        end else if (e > 0) begin
            r.right = 1'b1;
            r.amt   = SHAMT_W'(e);
        end else if (e >= -floor_shift) begin
            r.amt   = SHAMT_W'(-e);
        end else begin
            r.amt   = SHAMT_W'(floor_shift);
        end
        return r;
    endfunction

endpackage

// File: rtl/div_softmax_pow2_stream_lane.sv
// pow2_shift_lane: combinational shift/round/saturate for one lane.
// Ports: pow (unsigned power), right/amt (decoded shift), res (OUT_W
// quotient, all-ones when saturated), sat (lane saturated).
module pow2_shift_lane
    import div_softmax_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int OUT_W       = OUT_W_DEF,
    parameter int FLOOR_SHIFT = FLOOR_SHIFT_DEF,
    parameter int ROUND_EN    = ROUND_EN_DEF
) (
    input  logic [DIV_W-1:0]   pow,
    input  logic               right,
    input  logic [SHAMT_W-1:0] amt,
    output logic [OUT_W-1:0]   res,
    output logic               sat
);
    // Wide enough that the largest left shift never drops bits.
    localparam int INT_W = DIV_W + FLOOR_SHIFT;

    logic [INT_W-1:0] ext;
    logic [INT_W-1:0] rnd_src;
    logic [INT_W-1:0] shifted;
    logic             rbit;

    always_comb begin
        ext     = INT_W'(pow);
        // Bit (amt-1) of the unshifted value is the half-LSB for round-half-up.
        rnd_src = ext >> (amt - SHAMT_W'(1));
        rbit    = (ROUND_EN != 0) && right && (amt != '0) && rnd_src[0];
        shifted = right ? (ext >> amt) : (ext << amt);
        // Rounding first, so a round-up can push the value into saturation.
        shifted = shifted + INT_W'(rbit);
        sat     = shifted > INT_W'({OUT_W{1'b1}});
        res     = sat ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
    end

endmodule

// File: rtl/div_softmax_pow2_stream.sv
// div_softmax_pow2_stream: LANES-wide power / 2^(exp+BIAS) with AXI-stream
// handshake, 2-stage pipeline (S1 = decode, S2 = shift/round/saturate).
// Ports: aclk, rst_n (sync, active low); s_* input stream (tvalid/tready,
// exp, pow, tlast); m_* output stream (tvalid/tready, tdata, tlast, sat);
// clr_stats clears sat_cnt, which counts output beats with any lane saturated.
module div_softmax_pow2_stream
    import div_softmax_pkg::*;
#(
    parameter int LANES       = LANES_DEF,
    parameter int EXP_W       = EXP_W_DEF,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int OUT_W       = OUT_W_DEF,
    parameter int BIAS        = BIAS_DEF,
    parameter int EXP_FLOOR   = EXP_FLOOR_DEF,
    parameter int FLOOR_SHIFT = FLOOR_SHIFT_DEF,
    parameter int MAX_RSHIFT  = MAX_RSHIFT_DEF,
    parameter int ROUND_EN    = ROUND_EN_DEF
) (
    input  logic                   aclk,
    input  logic                   rst_n,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    input  logic [LANES*EXP_W-1:0] s_exp,
    input  logic [LANES*DIV_W-1:0] s_pow,
    input  logic                   s_tlast,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [LANES*OUT_W-1:0] m_tdata,
    output logic                   m_tlast,
    output logic [LANES-1:0]       m_sat,
    input  logic                   clr_stats,
    output logic [31:0]            sat_cnt
);
    logic                             s1_vld_q, s1_vld_d;
    logic                             s1_last_q, s1_last_d;
    logic [LANES-1:0][DIV_W-1:0]      s1_pow_q, s1_pow_d;
    shift_t [LANES-1:0]               s1_sh_q, s1_sh_d;
    logic                             m_vld_q, m_vld_d;
    logic                             m_last_q, m_last_d;
    logic [LANES-1:0][OUT_W-1:0]      m_data_q, m_data_d;
    logic [LANES-1:0]                 m_sat_q, m_sat_d;
    logic [31:0]                      sat_cnt_q, sat_cnt_d;

    shift_t [LANES-1:0]               lane_sh;
    logic [LANES-1:0][OUT_W-1:0]      lane_res;
    logic [LANES-1:0]                 lane_sat;
    logic                             s2_adv;
    logic                             accept;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [EXP_W-1:0] lane_exp;
        assign lane_exp   = s_exp[i*EXP_W +: EXP_W];
        assign lane_sh[i] = calc_shift(32'(lane_exp), BIAS, EXP_FLOOR,
                                       FLOOR_SHIFT, MAX_RSHIFT);

        pow2_shift_lane #(
            .DIV_W      (DIV_W),
            .OUT_W      (OUT_W),
            .FLOOR_SHIFT(FLOOR_SHIFT),
            .ROUND_EN   (ROUND_EN)
        ) u_lane (
            .pow  (s1_pow_q[i]),
            .right(s1_sh_q[i].right),
            .amt  (s1_sh_q[i].amt),
            .res  (lane_res[i]),
            .sat  (lane_sat[i])
        );
    end

    always_comb begin
        // S2 can take a new beat when empty or draining; S1 follows S2.
        s2_adv    = !m_vld_q || m_tready;
        s_tready  = rst_n && (!s1_vld_q || s2_adv);
        accept    = s_tvalid && s_tready;

        s1_vld_d  = s1_vld_q;
        s1_last_d = s1_last_q;
        s1_pow_d  = s1_pow_q;
        s1_sh_d   = s1_sh_q;
        m_vld_d   = m_vld_q;
        m_last_d  = m_last_q;
        m_data_d  = m_data_q;
        m_sat_d   = m_sat_q;
        sat_cnt_d = sat_cnt_q;

        if (accept) begin
            s1_vld_d  = 1'b1;
            s1_last_d = s_tlast;
            s1_pow_d  = s_pow;
            s1_sh_d   = lane_sh;
        end else if (s2_adv) begin
            s1_vld_d  = 1'b0;
        end

        if (s2_adv) begin
            m_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                m_data_d = lane_res;
                m_sat_d  = lane_sat;
                m_last_d = s1_last_q;
            end
        end

        // Clear beats a coincident increment; the count sticks at all-ones.
        if (clr_stats)
            sat_cnt_d = '0;
        else if (m_vld_q && m_tready && (|m_sat_q) && (sat_cnt_q != '1))
            sat_cnt_d = sat_cnt_q + 32'd1;
    end

    always_ff @(posedge aclk) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_pow_q  <= '0;
            s1_sh_q   <= '0;
            m_vld_q   <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
            m_sat_q   <= '0;
            sat_cnt_q <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_last_q <= s1_last_d;
            s1_pow_q  <= s1_pow_d;
            s1_sh_q   <= s1_sh_d;
            m_vld_q   <= m_vld_d;
            m_last_q  <= m_last_d;
            m_data_q  <= m_data_d;
            m_sat_q   <= m_sat_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    assign m_tvalid = m_vld_q;
    assign m_tdata  = m_data_q;
    assign m_tlast  = m_last_q;
    assign m_sat    = m_sat_q;
    assign sat_cnt  = sat_cnt_q;

endmodule

// File: tb/tb_div_softmax_pow2_stream.sv
// Directed bench for div_softmax_pow2_stream. A second instance built with
// ROUND_EN=0 shares the inputs so truncation can be compared beat for beat.
module tb_div_softmax_pow2_stream;

    logic        aclk = 1'b0;
    logic        rst_n;
    logic        s_tvalid, s_tlast, m_tready, clr_stats;
    logic [31:0] s_exp;
    logic [95:0] s_pow;

    logic        s_tready, m_tvalid, m_tlast;
    logic [63:0] m_tdata;
    logic [3:0]  m_sat;
    logic [31:0] sat_cnt;

    logic        s_tready_nr, m_tvalid_nr, m_tlast_nr;
    logic [63:0] m_tdata_nr;
    logic [3:0]  m_sat_nr;
    logic [31:0] sat_cnt_nr;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    div_softmax_pow2_stream dut (
        .aclk(aclk), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_exp(s_exp), .s_pow(s_pow), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tdata(m_tdata), .m_tlast(m_tlast), .m_sat(m_sat),
        .clr_stats(clr_stats), .sat_cnt(sat_cnt)
    );

    div_softmax_pow2_stream #(.ROUND_EN(0)) dut_nr (
        .aclk(aclk), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready_nr),
        .s_exp(s_exp), .s_pow(s_pow), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid_nr), .m_tready(m_tready),
        .m_tdata(m_tdata_nr), .m_tlast(m_tlast_nr), .m_sat(m_sat_nr),
        .clr_stats(clr_stats), .sat_cnt(sat_cnt_nr)
    );

    // Drives one beat with m_tready high and waits (bounded) for its output.
    task automatic send_one(input logic [31:0] ex, input logic [95:0] pw,
                            input logic last, output int lat,
                            output logic [63:0] d, output logic [3:0] sat,
                            output logic [63:0] d_nr, output logic [3:0] sat_nr,
                            output logic tl);
        @(negedge aclk);
        s_exp = ex; s_pow = pw; s_tlast = last; s_tvalid = 1'b1; m_tready = 1'b1;
        @(negedge aclk);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        lat = 1;
        while (!m_tvalid && lat < 10) begin
            @(negedge aclk);
            lat++;
        end
        d = m_tdata; sat = m_sat; d_nr = m_tdata_nr; sat_nr = m_sat_nr; tl = m_tlast;
    endtask

    function automatic logic [95:0] bp_pow(input int k);
        logic [95:0] v;
        for (int j = 0; j < 4; j++) v[j*24 +: 24] = 24'(24'h1000*(k+1) + 24'h100*j);
        return v;
    endfunction

    function automatic logic [63:0] bp_exp(input int k);
        logic [63:0] v;
        for (int j = 0; j < 4; j++) v[j*16 +: 16] = 16'(16'h100*(k+1) + 16'h10*j);
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        clr_stats = 1'b0; s_exp = '0; s_pow = '0;
        #1;
        n_chk++;
        if (s_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b want 0", s_tready); end
        repeat (3) @(negedge aclk);
        n_chk++;
        if ({m_tvalid, m_tlast, m_sat, m_tdata, sat_cnt} !== '0)
            begin n_fail++; $display("FAIL reset_state: valid=%b last=%b sat=%h data=%h cnt=%h want all 0",
                                     m_tvalid, m_tlast, m_sat, m_tdata, sat_cnt); end
        rst_n = 1'b1;
        @(negedge aclk);
        n_chk++;
        if (s_tready !== 1'b1) begin n_fail++; $display("FAIL post_reset_tready: got %b want 1", s_tready); end
    endtask

    task automatic test_basic();
        int lat; logic [63:0] d, dn; logic [3:0] st, sn; logic tl;
        send_one({8'hF6, 8'd9, 8'd8, 8'd0},
                 {24'h0003FF, 24'h123456, 24'hFFFFFF, 24'h000100}, 1'b1,
                 lat, d, st, dn, sn, tl);
        n_chk++;
        if (lat !== 2) begin n_fail++; $display("FAIL basic_latency: got %0d want 2", lat); end
        n_chk++;
        if (d !== 64'hFFC0_0123_1000_0010 || st !== 4'b0000)
            begin n_fail++; $display("FAIL basic_data: got %h sat %b want ffc0012310000010 sat 0000", d, st); end
        n_chk++;
        if (dn !== 64'hFFC0_0123_0FFF_0010)
            begin n_fail++; $display("FAIL basic_trunc: got %h want ffc001230fff0010", dn); end
        n_chk++;
        if (tl !== 1'b1) begin n_fail++; $display("FAIL basic_tlast: got %b want 1", tl); end
        @(negedge aclk);
        n_chk++;
        if (sat_cnt !== 32'd0 || m_tvalid !== 1'b0)
            begin n_fail++; $display("FAIL basic_drain: cnt=%0d valid=%b want 0 0", sat_cnt, m_tvalid); end
    endtask

    task automatic test_floor_sat();
        int lat; logic [63:0] d, dn; logic [3:0] st, sn; logic tl;
        send_one({24'd0, 8'hEC}, {72'd0, 24'h000001}, 1'b0, lat, d, st, dn, sn, tl);
        n_chk++;
        if (d !== 64'h0000_0000_0000_FFFF || st !== 4'b0001)
            begin n_fail++; $display("FAIL floor_sat: got %h sat %b want 000000000000ffff sat 0001", d, st); end
        @(negedge aclk);
        n_chk++;
        if (sat_cnt !== 32'd1) begin n_fail++; $display("FAIL floor_cnt: got %0d want 1", sat_cnt); end
        send_one({24'd0, 8'hED}, {72'd0, 24'h000001}, 1'b0, lat, d, st, dn, sn, tl);
        n_chk++;
        if (d !== 64'h0000_0000_0000_8000 || st !== 4'b0000)
            begin n_fail++; $display("FAIL floor_m19: got %h sat %b want 0000000000008000 sat 0000", d, st); end
        @(negedge aclk);
        n_chk++;
        if (sat_cnt !== 32'd1) begin n_fail++; $display("FAIL floor_cnt_hold: got %0d want 1", sat_cnt); end
    endtask

    task automatic test_clamp();
        int lat; logic [63:0] d, dn; logic [3:0] st, sn; logic tl;
        send_one({24'd0, 8'h7F}, {72'd0, 24'h00F000}, 1'b0, lat, d, st, dn, sn, tl);
        n_chk++;
        if (d !== 64'h0000_0000_0000_000F || st !== 4'b0000)
            begin n_fail++; $display("FAIL clamp: got %h sat %b want 000000000000000f sat 0000", d, st); end
    endtask

    task automatic test_rounding();
        int lat; logic [63:0] d, dn; logic [3:0] st, sn; logic tl;
        // lane0 0x18>>4, lane1 e=0 pass-through, lane2 0x1FFFF>>1 rounds into saturation
        send_one({8'd0, 8'hFD, 8'hFC, 8'd0},
                 {24'd0, 24'h01FFFF, 24'h00ABCD, 24'h000018}, 1'b0,
                 lat, d, st, dn, sn, tl);
        n_chk++;
        if (d !== 64'h0000_FFFF_ABCD_0002 || st !== 4'b0100)
            begin n_fail++; $display("FAIL round_on: got %h sat %b want 0000ffffabcd0002 sat 0100", d, st); end
        n_chk++;
        if (dn !== 64'h0000_FFFF_ABCD_0001 || sn !== 4'b0000)
            begin n_fail++; $display("FAIL round_off: got %h sat %b want 0000ffffabcd0001 sat 0000", dn, sn); end
        @(negedge aclk);
    endtask

    task automatic test_backpressure();
        int acc = 0, outn = 0;
        int hs_cyc[6];
        logic stall_seen = 1'b0, prev_stall = 1'b0;
        logic [63:0] prev_d = '0;
        for (int cyc = 0; cyc < 30 && outn < 6; cyc++) begin
            @(negedge aclk);
            s_tvalid = (acc < 6);
            s_exp    = '0;
            s_pow    = bp_pow(acc);
            s_tlast  = (acc == 5);
            m_tready = !(cyc >= 3 && cyc <= 8);
            #1;
            if (prev_stall) begin
                n_chk++;
                if (m_tdata !== prev_d || m_tvalid !== 1'b1)
                    begin n_fail++; $display("FAIL bp_hold: cyc %0d got %h valid %b want %h valid 1",
                                             cyc, m_tdata, m_tvalid, prev_d); end
            end
            if (s_tvalid && !s_tready && !stall_seen) begin
                stall_seen = 1'b1;
                n_chk++;
                if (acc - outn !== 2)
                    begin n_fail++; $display("FAIL bp_buffered: got %0d beats held want 2", acc - outn); end
            end
            if (m_tvalid && m_tready) begin
                n_chk++;
                if (m_tdata !== bp_exp(outn) || m_tlast !== (outn == 5))
                    begin n_fail++; $display("FAIL bp_beat%0d: got %h last %b want %h last %b",
                                             outn, m_tdata, m_tlast, bp_exp(outn), (outn == 5)); end
                hs_cyc[outn] = cyc;
                outn++;
            end
            if (s_tvalid && s_tready) acc++;
            prev_stall = m_tvalid && !m_tready;
            prev_d     = m_tdata;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        n_chk++;
        if (outn !== 6 || !stall_seen)
            begin n_fail++; $display("FAIL bp_count: got %0d outputs stall %b want 6 1", outn, stall_seen); end
        else begin
            n_chk++;
            if (hs_cyc[0] !== 2 || hs_cyc[1] !== 9 || hs_cyc[5] - hs_cyc[1] !== 4)
                begin n_fail++; $display("FAIL bp_timing: out0 cyc %0d out1 cyc %0d out5 cyc %0d want 2 9 13",
                                         hs_cyc[0], hs_cyc[1], hs_cyc[5]); end
        end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        @(negedge aclk);
        m_tready = 1'b0;
        s_exp = {24'd0, 8'hEC}; s_pow = {72'd0, 24'h000001}; s_tvalid = 1'b1;
        @(negedge aclk);
        @(negedge aclk);
        s_tvalid = 1'b0; rst_n = 1'b0;
        #1;
        n_chk++;
        if (s_tready !== 1'b0) begin n_fail++; $display("FAIL mid_reset_tready: got %b want 0", s_tready); end
        @(negedge aclk);
        rst_n = 1'b1; m_tready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge aclk);
            if (m_tvalid) seen++;
        end
        n_chk++;
        if (seen !== 0 || sat_cnt !== 32'd0)
            begin n_fail++; $display("FAIL mid_reset_flush: got %0d outputs cnt %0d want 0 0", seen, sat_cnt); end
    endtask

    task automatic test_clr_stats();
        int lat; logic [63:0] d, dn; logic [3:0] st, sn; logic tl;
        send_one({24'd0, 8'hEC}, {72'd0, 24'h000001}, 1'b0, lat, d, st, dn, sn, tl);
        @(negedge aclk);
        n_chk++;
        if (sat_cnt !== 32'd1) begin n_fail++; $display("FAIL clr_pre: got %0d want 1", sat_cnt); end
        send_one({24'd0, 8'hEC}, {72'd0, 24'h000001}, 1'b0, lat, d, st, dn, sn, tl);
        clr_stats = 1'b1;
        @(negedge aclk);
        clr_stats = 1'b0;
        n_chk++;
        if (sat_cnt !== 32'd0 || m_tvalid !== 1'b0)
            begin n_fail++; $display("FAIL clr_coincident: cnt %0d valid %b want 0 0", sat_cnt, m_tvalid); end
    endtask

    task automatic test_sat_hold();
        int lat; logic [63:0] d, dn; logic [3:0] st, sn; logic tl;
        @(negedge aclk);
        force dut.sat_cnt_q = 32'hFFFF_FFFF;
        @(negedge aclk);
        release dut.sat_cnt_q;
        @(negedge aclk);
        n_chk++;
        if (sat_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sat_preload: got %h want ffffffff", sat_cnt); end
        send_one({24'd0, 8'hEC}, {72'd0, 24'h000001}, 1'b0, lat, d, st, dn, sn, tl);
        @(negedge aclk);
        n_chk++;
        if (sat_cnt !== 32'hFFFF_FFFF || m_tvalid !== 1'b0)
            begin n_fail++; $display("FAIL sat_no_wrap: got %h valid %b want ffffffff 0", sat_cnt, m_tvalid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_floor_sat();
        test_clamp();
        test_rounding();
        test_backpressure();
        test_reset_midflight();
        test_clr_stats();
        test_sat_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
